// File: rtl/ysyx_22040759_id_stage.sv
// Decode stage: holds one fetched RV64I instruction, decodes fields/immediates/enables for execute.
// Latency: 1 cycle from fetch accept to ds_to_es_valid; back-pressure via ds_allowin (es_allowin, stall).
// Optional DS_PERF_CNT_EN adds 64-bit stall/flush event counters.
module ysyx_22040759_id_stage #(
    parameter  int XLEN     = 64,
    localparam int DS_BUS_W = 55 + 2 * XLEN
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fs_to_ds_valid,
    input  logic [95:0]         fs_to_ds_bus,
    output logic                ds_allowin,
    input  logic                es_allowin,
    input  logic                stall,
    input  logic                flush,
    output logic                ds_to_es_valid,
    output logic [DS_BUS_W-1:0] ds_to_es_bus,
    output logic [4:0]          ds_rs1,
    output logic [4:0]          ds_rs2
`ifdef DS_PERF_CNT_EN
    ,
    output logic [63:0]         ds_stall_cnt,
    output logic [63:0]         ds_flush_cnt
`endif
);

    typedef enum logic [3:0] {
        OC_LUI     = 4'd0,
        OC_AUIPC   = 4'd1,
        OC_JAL     = 4'd2,
        OC_JALR    = 4'd3,
        OC_BRANCH  = 4'd4,
        OC_LOAD    = 4'd5,
        OC_STORE   = 4'd6,
        OC_OP_IMM  = 4'd7,
        OC_OP      = 4'd8,
        OC_OP_IMM32= 4'd9,
        OC_OP32    = 4'd10,
        OC_SYSTEM  = 4'd11,
        OC_ILLEGAL = 4'd15
    } op_class_e;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_sel_e;

    typedef struct packed {
        logic            illegal;
        logic            rs2_ren;
        logic            rs1_ren;
        logic            rf_we;
        logic [3:0]      op_class;
        logic [4:0]      rd;
        logic [4:0]      rs2;
        logic [4:0]      rs1;
        logic [XLEN-1:0] imm;
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
    } ds_es_bus_t;

    logic            r_ds_valid;
    logic [XLEN-1:0] r_ds_pc;
    logic [31:0]     r_ds_inst;

    logic            w_ready_go;
    op_class_e       w_cls;
    imm_sel_e        w_imm_sel;
    logic [XLEN-1:0] w_imm;
    logic            w_rs1_ren;
    logic            w_rs2_ren;
    logic            w_rf_we;
    ds_es_bus_t      w_bus;

    assign w_ready_go     = !stall;
    assign ds_allowin     = !r_ds_valid || (w_ready_go && es_allowin);
    assign ds_to_es_valid = r_ds_valid && w_ready_go && !flush;

    // Flush wins over accept so the instruction behind a redirect never enters decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ds_valid <= 1'b0;
            r_ds_pc    <= '0;
            r_ds_inst  <= '0;
        end else if (flush) begin
            r_ds_valid <= 1'b0;
        end else if (ds_allowin) begin
            r_ds_valid <= fs_to_ds_valid;
            if (fs_to_ds_valid) begin
                r_ds_pc   <= fs_to_ds_bus[63:0];
                r_ds_inst <= fs_to_ds_bus[95:64];
            end
        end
    end

    always_comb begin
        w_cls     = OC_ILLEGAL;
        w_imm_sel = IMM_NONE;
        if (r_ds_inst[1:0] == 2'b11) begin
            case (r_ds_inst[6:2])
                5'b01101: begin w_cls = OC_LUI;      w_imm_sel = IMM_U; end
                5'b00101: begin w_cls = OC_AUIPC;    w_imm_sel = IMM_U; end
                5'b11011: begin w_cls = OC_JAL;      w_imm_sel = IMM_J; end
                5'b11001: begin w_cls = OC_JALR;     w_imm_sel = IMM_I; end
                5'b11000: begin w_cls = OC_BRANCH;   w_imm_sel = IMM_B; end
                5'b00000: begin w_cls = OC_LOAD;     w_imm_sel = IMM_I; end
                5'b01000: begin w_cls = OC_STORE;    w_imm_sel = IMM_S; end
                5'b00100: begin w_cls = OC_OP_IMM;   w_imm_sel = IMM_I; end
                5'b01100: begin w_cls = OC_OP;       w_imm_sel = IMM_NONE; end
                5'b00110: begin w_cls = OC_OP_IMM32; w_imm_sel = IMM_I; end
                5'b01110: begin w_cls = OC_OP32;     w_imm_sel = IMM_NONE; end
                5'b11100: begin w_cls = OC_SYSTEM;   w_imm_sel = IMM_I; end
                default:  begin w_cls = OC_ILLEGAL;  w_imm_sel = IMM_NONE; end
            endcase
        end
    end

    always_comb begin
        w_imm = '0;
        case (w_imm_sel)
            IMM_I: w_imm = {{(XLEN-12){r_ds_inst[31]}}, r_ds_inst[31:20]};
            IMM_S: w_imm = {{(XLEN-12){r_ds_inst[31]}}, r_ds_inst[31:25], r_ds_inst[11:7]};
            IMM_B: w_imm = {{(XLEN-13){r_ds_inst[31]}}, r_ds_inst[31], r_ds_inst[7],
                            r_ds_inst[30:25], r_ds_inst[11:8], 1'b0};
            IMM_U: w_imm = {{(XLEN-32){r_ds_inst[31]}}, r_ds_inst[31:12], 12'b0};
            IMM_J: w_imm = {{(XLEN-21){r_ds_inst[31]}}, r_ds_inst[31], r_ds_inst[19:12],
                            r_ds_inst[20], r_ds_inst[30:21], 1'b0};
            default: w_imm = '0;
        endcase
    end

    assign w_rs1_ren = w_cls inside {OC_JALR, OC_BRANCH, OC_LOAD, OC_STORE,
                                     OC_OP_IMM, OC_OP, OC_OP_IMM32, OC_OP32};
    assign w_rs2_ren = w_cls inside {OC_BRANCH, OC_STORE, OC_OP, OC_OP32};
    assign w_rf_we   = (w_cls inside {OC_LUI, OC_AUIPC, OC_JAL, OC_JALR, OC_LOAD,
                                      OC_OP_IMM, OC_OP, OC_OP_IMM32, OC_OP32})
                       && (r_ds_inst[11:7] != 5'd0);

    always_comb begin
        w_bus          = '0;
        w_bus.illegal  = (w_cls == OC_ILLEGAL);
        w_bus.rs2_ren  = w_rs2_ren;
        w_bus.rs1_ren  = w_rs1_ren;
        w_bus.rf_we    = w_rf_we;
        w_bus.op_class = w_cls;
        w_bus.rd       = r_ds_inst[11:7];
        w_bus.rs2      = r_ds_inst[24:20];
        w_bus.rs1      = r_ds_inst[19:15];
        w_bus.imm      = w_imm;
        w_bus.inst     = r_ds_inst;
        w_bus.pc       = r_ds_pc;
    end

    assign ds_to_es_bus = w_bus;
    assign ds_rs1       = w_rs1_ren ? r_ds_inst[19:15] : 5'd0;
    assign ds_rs2       = w_rs2_ren ? r_ds_inst[24:20] : 5'd0;

`ifdef DS_PERF_CNT_EN
    logic [63:0] r_stall_cnt;
    logic [63:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (r_ds_valid && stall) r_stall_cnt <= r_stall_cnt + 64'd1;
            if (r_ds_valid && flush) r_flush_cnt <= r_flush_cnt + 64'd1;
        end
    end

    assign ds_stall_cnt = r_stall_cnt;
    assign ds_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_ysyx_22040759_id_stage.sv
// Bench for the decode stage: decode vector table, hand-written stall/flush/back-pressure/reset
// sequences, then randomized traffic against a cycle-level reference model.
module tb_ysyx_22040759_id_stage;

    logic         clk;
    logic         rst_n;
    logic         fs_to_ds_valid;
    logic [95:0]  fs_to_ds_bus;
    logic         ds_allowin;
    logic         es_allowin;
    logic         stall;
    logic         flush;
    logic         ds_to_es_valid;
    logic [182:0] ds_to_es_bus;
    logic [4:0]   ds_rs1;
    logic [4:0]   ds_rs2;
`ifdef DS_PERF_CNT_EN
    logic [63:0]  ds_stall_cnt;
    logic [63:0]  ds_flush_cnt;
`endif

    ysyx_22040759_id_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus),
        .ds_allowin     (ds_allowin),
        .es_allowin     (es_allowin),
        .stall          (stall),
        .flush          (flush),
        .ds_to_es_valid (ds_to_es_valid),
        .ds_to_es_bus   (ds_to_es_bus),
        .ds_rs1         (ds_rs1),
        .ds_rs2         (ds_rs2)
`ifdef DS_PERF_CNT_EN
        ,
        .ds_stall_cnt   (ds_stall_cnt),
        .ds_flush_cnt   (ds_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference state: what decode should be holding.
    logic        m_valid;
    logic [63:0] m_pc;
    logic [31:0] m_inst;
    logic [63:0] m_stall_cnt;
    logic [63:0] m_flush_cnt;

    task automatic check(input string name, input logic [182:0] act, input logic [182:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic [182:0] ref_bus(input logic [31:0] in, input logic [63:0] pc);
        int     cls;
        longint imm;
        logic   r1, r2, we;
        cls = 15;
        if (in[1:0] == 2'b11) begin
            case (in[6:0])
                7'b0110111: cls = 0;
                7'b0010111: cls = 1;
                7'b1101111: cls = 2;
                7'b1100111: cls = 3;
                7'b1100011: cls = 4;
                7'b0000011: cls = 5;
                7'b0100011: cls = 6;
                7'b0010011: cls = 7;
                7'b0110011: cls = 8;
                7'b0011011: cls = 9;
                7'b0111011: cls = 10;
                7'b1110011: cls = 11;
                default:    cls = 15;
            endcase
        end
        imm = 0;
        if (cls inside {3, 5, 7, 9, 11}) imm = longint'($signed(in[31:20]));
        else if (cls == 6) imm = longint'($signed({in[31:25], in[11:7]}));
        else if (cls == 4) imm = -4096 * longint'(in[31]) + 2048 * longint'(in[7])
                                 + 32 * longint'(in[30:25]) + 2 * longint'(in[11:8]);
        else if (cls inside {0, 1}) imm = longint'($signed(in[31:12])) * 4096;
        else if (cls == 2) imm = -1048576 * longint'(in[31]) + 4096 * longint'(in[19:12])
                                 + 2048 * longint'(in[20]) + 2 * longint'(in[30:21]);
        r1 = (cls inside {3, 4, 5, 6, 7, 8, 9, 10});
        r2 = (cls inside {4, 6, 8, 10});
        we = (cls inside {0, 1, 2, 3, 5, 7, 8, 9, 10}) && (in[11:7] != 5'd0);
        return {(cls == 15), r2, r1, we, 4'(cls), in[11:7], in[24:20], in[19:15], imm, in, pc};
    endfunction

    task automatic model_clear();
        m_valid     = 1'b0;
        m_pc        = '0;
        m_inst      = '0;
        m_stall_cnt = '0;
        m_flush_cnt = '0;
    endtask

    task automatic model_edge();
        logic allow;
        if (!rst_n) begin
            model_clear();
        end else begin
            allow = !m_valid || (!stall && es_allowin);
            if (m_valid && stall) m_stall_cnt = m_stall_cnt + 64'd1;
            if (m_valid && flush) m_flush_cnt = m_flush_cnt + 64'd1;
            if (flush) m_valid = 1'b0;
            else if (allow) begin
                m_valid = fs_to_ds_valid;
                if (fs_to_ds_valid) begin
                    m_pc   = fs_to_ds_bus[63:0];
                    m_inst = fs_to_ds_bus[95:64];
                end
            end
        end
    endtask

    task automatic compare_model();
        logic [182:0] eb;
        eb = ref_bus(m_inst, m_pc);
        check("to_es_valid", ds_to_es_valid, m_valid && !stall && !flush);
        check("allowin", ds_allowin, !m_valid || (!stall && es_allowin));
        check("bus", ds_to_es_bus, eb);
        check("ds_rs1", ds_rs1, eb[180] ? m_inst[19:15] : 5'd0);
        check("ds_rs2", ds_rs2, eb[181] ? m_inst[24:20] : 5'd0);
`ifdef DS_PERF_CNT_EN
        check("stall_cnt", ds_stall_cnt, m_stall_cnt);
        check("flush_cnt", ds_flush_cnt, m_flush_cnt);
`endif
    endtask

    // Compare at the falling edge, advance one rising edge, return 1 time unit after it.
    task automatic step();
        @(negedge clk);
        compare_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] in, input logic [63:0] pc,
                         input logic ea, input logic st, input logic fl);
        fs_to_ds_valid = v;
        fs_to_ds_bus   = {in, pc};
        es_allowin     = ea;
        stall          = st;
        flush          = fl;
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [3:0]  cls;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs2;
        logic [4:0]  rs1;
        logic        we;
        logic        r1;
        logic        r2;
        logic        ill;
    } vec_t;

    vec_t tab[10];

    logic [4:0]  opc_list[12] = '{5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b11000, 5'b00000,
                                  5'b01000, 5'b00100, 5'b01100, 5'b00110, 5'b01110, 5'b11100};

    initial begin
        logic [31:0] ri;
        logic [63:0] rp;

        tab[0] = '{32'h00500093, 64'h80000000, 4'd7,  64'd5,                  5'd1,  5'd5,  5'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tab[1] = '{32'hFE208CE3, 64'h80000004, 4'd4,  64'hFFFFFFFFFFFFFFF8,   5'd25, 5'd2,  5'd1, 1'b0, 1'b1, 1'b1, 1'b0};
        tab[2] = '{32'h800002B7, 64'h80000008, 4'd0,  64'hFFFFFFFF80000000,   5'd5,  5'd0,  5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[3] = '{32'h00000000, 64'h8000000C, 4'd15, 64'd0,                  5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        tab[4] = '{32'h00000013, 64'h00000000, 4'd7,  64'd0,                  5'd0,  5'd0,  5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        tab[5] = '{32'h002081B3, 64'h80000010, 4'd8,  64'd0,                  5'd3,  5'd2,  5'd1, 1'b1, 1'b1, 1'b1, 1'b0};
        tab[6] = '{32'h0020B423, 64'h80000014, 4'd6,  64'd8,                  5'd8,  5'd2,  5'd1, 1'b0, 1'b1, 1'b1, 1'b0};
        tab[7] = '{32'h010000EF, 64'h80000018, 4'd2,  64'd16,                 5'd1,  5'd16, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[8] = '{32'h00500090, 64'h8000001C, 4'd15, 64'd0,                  5'd1,  5'd5,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        tab[9] = '{32'h00008067, 64'h80000020, 4'd3,  64'd0,                  5'd0,  5'd0,  5'd1, 1'b0, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b1;
        drive(1'b1, 32'h12345013, 64'hDEAD, 1'b1, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #2;
        model_clear();
        check("rst_to_es_valid", ds_to_es_valid, 1'b0);
        check("rst_allowin", ds_allowin, 1'b1);
`ifdef DS_PERF_CNT_EN
        check("rst_stall_cnt", ds_stall_cnt, 64'd0);
        check("rst_flush_cnt", ds_flush_cnt, 64'd0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Back-to-back decode table, one instruction per cycle.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, tab[i].inst, tab[i].pc, 1'b1, 1'b0, 1'b0);
            step();
            check($sformatf("tab%0d_dec", i), ds_to_es_bus[182:96],
                  {tab[i].ill, tab[i].r2, tab[i].r1, tab[i].we, tab[i].cls,
                   tab[i].rd, tab[i].rs2, tab[i].rs1, tab[i].imm});
            check($sformatf("tab%0d_pc", i), ds_to_es_bus[63:0], tab[i].pc);
            check($sformatf("tab%0d_valid", i), ds_to_es_valid, 1'b1);
            check($sformatf("tab%0d_rs1", i), ds_rs1, tab[i].r1 ? tab[i].rs1 : 5'd0);
            check($sformatf("tab%0d_rs2", i), ds_rs2, tab[i].r2 ? tab[i].rs2 : 5'd0);
        end

        // Stall two cycles, then flush while fetch offers a new instruction.
        drive(1'b1, 32'h0020B423, 64'h80000100, 1'b1, 1'b0, 1'b0);
        step();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'h00500093, 64'h80000104, 1'b1, 1'b1, 1'b0);
            step();
            check("stall_valid", ds_to_es_valid, 1'b0);
            check("stall_allowin", ds_allowin, 1'b0);
            check("stall_rs", {ds_rs1, ds_rs2}, {5'd1, 5'd2});
            check("stall_pc", ds_to_es_bus[63:0], 64'h80000100);
        end
`ifdef DS_PERF_CNT_EN
        check("stall_cnt2", ds_stall_cnt, 64'd2);
`endif
        drive(1'b1, 32'h00500093, 64'h80000104, 1'b1, 1'b0, 1'b1);
        step();
        flush = 1'b0;
        fs_to_ds_valid = 1'b0;
        #1;
        check("flush_valid", ds_to_es_valid, 1'b0);
        check("flush_allowin", ds_allowin, 1'b1);
        check("flush_dropped_pc", ds_to_es_bus[63:0], 64'h80000100);
`ifdef DS_PERF_CNT_EN
        check("flush_cnt1", ds_flush_cnt, 64'd1);
`endif

        // Execute back-pressure for three cycles.
        drive(1'b1, 32'h800002B7, 64'h80000200, 1'b1, 1'b0, 1'b0);
        step();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h002081B3, 64'h80000204, 1'b0, 1'b0, 1'b0);
            step();
            check("bp_allowin", ds_allowin, 1'b0);
            check("bp_hold_pc", ds_to_es_bus[63:0], 64'h80000200);
            check("bp_hold_inst", ds_to_es_bus[95:64], 32'h800002B7);
        end
        es_allowin = 1'b1;
        step();
        check("bp_release_pc", ds_to_es_bus[63:0], 64'h80000204);
        check("bp_release_valid", ds_to_es_valid, 1'b1);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) < 85) begin
                ri = $urandom;
                ri[6:2] = opc_list[$urandom_range(0, 11)];
                ri[1:0] = ($urandom_range(0, 19) == 0) ? 2'b01 : 2'b11;
            end else begin
                ri = $urandom;
            end
            rp = {32'($urandom), 32'($urandom)};
            drive($urandom_range(0, 3) != 0, ri, rp, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
            step();
        end

        // Mid-cycle reset with a valid instruction held, then first accept after release.
        drive(1'b1, 32'h00500093, 64'h80000300, 1'b1, 1'b0, 1'b0);
        step();
        rst_n = 1'b0;
        #2;
        model_clear();
        check("mrst_to_es_valid", ds_to_es_valid, 1'b0);
        check("mrst_allowin", ds_allowin, 1'b1);
        check("mrst_pc", ds_to_es_bus[63:0], 64'd0);
`ifdef DS_PERF_CNT_EN
        check("mrst_stall_cnt", ds_stall_cnt, 64'd0);
        check("mrst_flush_cnt", ds_flush_cnt, 64'd0);
`endif
        drive(1'b1, 32'h00700113, 64'h80000400, 1'b1, 1'b0, 1'b0);
        step();
        check("rst_no_sample", ds_to_es_valid, 1'b0);
        rst_n = 1'b1;
        drive(1'b1, 32'h00900193, 64'h80000500, 1'b1, 1'b0, 1'b0);
        step();
        check("post_rst_valid", ds_to_es_valid, 1'b1);
        check("post_rst_pc", ds_to_es_bus[63:0], 64'h80000500);
        fs_to_ds_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ysyx_22040759_id_stage.md
Name: ysyx_22040759_id_stage

Overview:
Decode stage sitting directly downstream of the fetch stage. It consumes the fetch stage's 96-bit {inst, pc} bus through a valid/allowin handshake and holds one instruction in a pipeline register. It decodes RV64I fields, immediates and operand-read enables, then presents a registered-valid bus to the execute stage. It supports a hazard stall and a branch-redirect flush.

Parameters:
XLEN, 64, PC and immediate width
DS_BUS_W, 183, width of ds_to_es_bus (fixed by field list below; not user-tunable)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
fs_to_ds_valid  in  1  fetch stage holds a valid instruction
fs_to_ds_bus  in  96  {inst[95:64], pc[63:0]}
ds_allowin  out  1  decode can accept this cycle
es_allowin  in  1  execute can accept this cycle
stall  in  1  hazard unit holds the instruction in decode
flush  in  1  branch redirect; kill the decode-stage instruction
ds_to_es_valid  out  1  decode output valid
ds_to_es_bus  out  183  {illegal, rs2_ren, rs1_ren, rf_we, op_class[3:0], rd[4:0], rs2[4:0], rs1[4:0], imm[63:0], inst[31:0], pc[63:0]}; bits 182..0 in that order
ds_rs1  out  5  rs1 of the held instruction, for the hazard unit (0 when !rs1_ren)
ds_rs2  out  5  rs2 of the held instruction (0 when !rs2_ren)

Behaviour:
- State: ds_valid (1b), ds_pc (64b), ds_inst (32b); all cleared to 0 asynchronously when rst_n=0.
- ds_ready_go = !stall.
- ds_allowin = !ds_valid || (ds_ready_go && es_allowin); combinational, no dependency on fs_to_ds_valid.
- ds_to_es_valid = ds_valid && ds_ready_go && !flush.
- On posedge clk, in priority order:
  - flush: ds_valid <= 0. The incoming instruction is dropped, even when fs_to_ds_valid && ds_allowin.
  - else if ds_allowin: ds_valid <= fs_to_ds_valid. When fs_to_ds_valid=1, ds_pc and ds_inst also load from the bus.
  - else: hold.
- Latency: an instruction accepted in cycle N appears on ds_to_es_bus in cycle N+1. Throughput is 1 instruction per cycle when es_allowin=1 and stall=0.
- stall with ds_valid=1: ds_to_es_valid=0, ds_allowin=0, and the register holds. Stall with ds_valid=0 has no effect (ds_allowin=1).
- Reset deasserting mid-stream: the first accept occurs on the first posedge after release. The bus is not sampled during reset.
- Decode (combinational from ds_inst), opcode=inst[6:2]. op_class encoding:
  - 0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE
  - 7 OP_IMM, 8 OP, 9 OP_IMM_32, 10 OP_32, 11 SYSTEM
  - 15 illegal: unknown opcode, or inst[1:0]!=2'b11.
- Immediates, sign-extended from inst[31] to 64 bits:
  - I: JALR, LOAD, OP_IMM, OP_IMM_32, SYSTEM
  - S: STORE
  - B: BRANCH, bit0=0
  - U: LUI, AUIPC, low 12 bits=0
  - J: JAL
  - imm=0 for OP, OP_32 and illegal.
- rs1_ren: JALR, BRANCH, LOAD, STORE, OP_IMM, OP, OP_IMM_32, OP_32.
- rs2_ren: BRANCH, STORE, OP, OP_32.
- rf_we: LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP, OP_IMM_32, OP_32; forced 0 when rd==0 or illegal.
- illegal=1 only when op_class==15. On illegal, all read/write enables are 0.
- The fetch-stage bubble (inst=0x00000013, pc=0) decodes as OP_IMM with rd=0, so rf_we=0. It flows as a normal valid instruction.

Optional Feature:
DS_PERF_CNT_EN
- Defined: adds outputs ds_stall_cnt[63:0] and ds_flush_cnt[63:0], both async-reset to 0.
  - ds_stall_cnt increments each cycle with ds_valid && stall.
  - ds_flush_cnt increments each cycle with flush && ds_valid.
  - Both wrap from all-ones to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 mid-cycle -> ds_valid=0, ds_to_es_valid=0, ds_allowin=1 immediately; the counters (if DS_PERF_CNT_EN) read 0.
- Accept addi x1,x0,5 (0x00500093, pc=0x80000000) with es_allowin=1 -> next cycle ds_to_es_valid=1, op_class=7, imm=5, rd=1, rs1=0, rf_we=1, rs1_ren=1, rs2_ren=0.
- beq x1,x2,-8 (0xFE208CE3) -> op_class=4, imm=0xFFFFFFFFFFFFFFF8, rs1=1, rs2=2, rf_we=0. lui x5,0x80000 (0x800002B7) -> imm=0xFFFFFFFF80000000, rd=5.
- Back-pressure: es_allowin=0 for 3 cycles with fs_to_ds_valid=1 -> ds_allowin=0 and the held instruction is unchanged. Then es_allowin=1 -> the next instruction loads on the following edge.
- stall=1 for 2 cycles with a valid instruction -> ds_to_es_valid=0, ds_rs1/ds_rs2 stable, ds_stall_cnt=2. Then flush=1 together with fs_to_ds_valid=1 -> ds_valid=0 next cycle and the incoming instruction is dropped.
- Illegal: inst=0x00000000 -> op_class=15, illegal=1, rf_we=0, rs1_ren=0, rs2_ren=0, ds_to_es_valid still 1.
